instr_fetch_unit: RTL

- Producer side of the instruction register interface: fetches 16-bit instruction words from instruction memory and presents them, one at a time, to the decode/control block's IR load port.
- Holds the fetch PC and a small prefetch FIFO.
- Accepts branch/jump redirects from control, flushing stale prefetched words.
- Sits between instruction memory and the IR/control/register-file block.

---
 rtl/instr_fetch_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: issues word reads to instruction memory, buffers
// the returned words in a small prefetch FIFO and hands them to the IR load port.
module instr_fetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        ir_valid,
  output logic [15:0] ir_out,
  output logic [15:0] ir_pc,
  output logic [15:0] ir_pc_plus1,
  input  logic        ir_take,
  output logic        ir_wrt,
  input  logic        redirect,
  input  logic [15:0] redirect_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]    state;
  logic [15:0]   fetch_pc;
  logic [15:0]   addr_q;
  logic [15:0]   fifo_data [DEPTH];
  logic [15:0]   fifo_pc   [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_after;
  logic          push;
  logic          pop;

  // Memory side: mem_req/mem_addr stay put until a cycle with mem_ack=1, and the
  // word is captured on that edge. IR side: a word moves when ir_valid & ir_take,
  // unless a redirect in the same cycle cancels the transfer.
  assign mem_req  = (state == REQ) || (state == DROP);
  assign mem_addr = addr_q;

  assign ir_valid    = (count != '0);
  assign ir_out      = ir_valid ? fifo_data[rd_ptr] : 16'h0000;
  assign ir_pc       = ir_valid ? fifo_pc[rd_ptr]   : 16'h0000;
  assign ir_pc_plus1 = ir_pc + 16'd1;
  assign ir_wrt      = ir_valid & ir_take & ~redirect;

  assign pop         = ir_wrt;
  assign push        = (state == REQ) & mem_ack & ~redirect;
  assign count_after = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= mem_rdata;
      fifo_pc[wr_ptr]   <= fetch_pc;
    end
  end

  // addr_q tracks fetch_pc in REQ; in DROP it keeps the abandoned address
  // while fetch_pc already points at the redirect target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fetch_pc <= redirect_pc;
      case (state)
        IDLE: begin
          state  <= REQ;
          addr_q <= redirect_pc;
        end
        REQ, DROP: begin
          if (mem_ack) begin
            state  <= REQ;
            addr_q <= redirect_pc;
          end else begin
            state <= DROP;
          end
        end
        default: state <= IDLE;
      endcase
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_after;
      case (state)
        IDLE: begin
          if (count < FULL) begin
            state  <= REQ;
            addr_q <= fetch_pc;
          end
        end
        REQ: begin
          if (mem_ack) begin
            fetch_pc <= fetch_pc + 16'd1;
            addr_q   <= fetch_pc + 16'd1;
            state    <= (count_after < FULL) ? REQ : IDLE;
          end
        end
        DROP: begin
          if (mem_ack) begin
            state  <= REQ;
            addr_q <= fetch_pc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
